// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package riscv_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;   // wait-state counter covers 0..15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enabled synchronous write and combinational read.
module dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [BE_W-1:0]          be,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset branch; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// Valid/ready data-memory responder with fixed wait states and error checking.
// Define DMEM_BYTE_EN for per-byte stores; otherwise every store writes the full word.
module dmem_resp
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              go_resp;

    logic              we_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;

    logic              req_err;
    logic [BE_W-1:0]   req_be_eff;
    logic              cur_we;
    logic [AW-1:0]     cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic              cur_err;
    logic [WORD_W-1:0] mem_rdata;

    // Out-of-range indices flag an error instead of aliasing onto low words.
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[WORD_W-1:AW+2] != '0);

`ifdef DMEM_BYTE_EN
    assign req_be_eff = req_be;
`else
    logic unused_be;
    assign unused_be  = ^req_be;
    assign req_be_eff = '1;
`endif

    // With zero wait states the commit edge is the accept edge, so use the live request.
    assign cur_we    = (state == IDLE) ? req_we                : we_q;
    assign cur_idx   = (state == IDLE) ? req_addr[AW+1:2]      : idx_q;
    assign cur_wdata = (state == IDLE) ? req_wdata             : wdata_q;
    assign cur_be    = (state == IDLE) ? req_be_eff            : be_q;
    assign cur_err   = (state == IDLE) ? req_err               : err_q;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (go_resp && cur_we && !cur_err),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (mem_rdata)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        go_resp   = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                idx_q   <= req_addr[AW+1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be_eff;
                err_q   <= req_err;
            end
            if (go_resp) begin
                rsp_rdata <= (cur_err || cur_we) ? '0 : mem_rdata;
                rsp_err   <= cur_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance with two wait states, one with none.
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_resp #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts #1 after a rising edge with the DUT idle; returns #1 after the completing edge.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        check({tag, " req_ready"}, req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'h0000_0004;
        req_wdata = ~wdata;
        req_be    = ~be;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 3);
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, rsp_valid, 1);
            check({tag, " hold rdata"}, rsp_rdata, exp_rdata);
            check({tag, " hold err"}, rsp_err, exp_err);
            check({tag, " hold req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " idle rsp_valid"}, rsp_valid, 0);
        check({tag, " idle req_ready"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_be, exp_be0;
        logic        prev_acc;
        int          acc_count;

        reset     = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
        z_rsp_ready = 1'b1;

        @(negedge clk);
        check("reset req_ready", req_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset rsp_err", rsp_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        do_req("store 0x64", 1'b1, 32'h64, 32'h0000_0019, 4'hF, 0, 32'h0, 1'b0);
        do_req("load 0x64",  1'b0, 32'h64, 32'h0,        4'hF, 0, 32'h0000_0019, 1'b0);

`ifdef DMEM_BYTE_EN
        exp_be  = 32'h1122_CC44;
        exp_be0 = 32'h1122_CC44;
`else
        exp_be  = 32'hAABB_CCDD;
        exp_be0 = 32'hFFFF_FFFF;
`endif
        do_req("store full 0x10", 1'b1, 32'h10, 32'h1122_3344, 4'hF, 0, 32'h0, 1'b0);
        do_req("store be2 0x10",  1'b1, 32'h10, 32'hAABB_CCDD, 4'h2, 0, 32'h0, 1'b0);
        do_req("load be 0x10",    1'b0, 32'h10, 32'h0,         4'hF, 0, exp_be, 1'b0);
        do_req("store be0 0x10",  1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0);
        do_req("load be0 0x10",   1'b0, 32'h10, 32'h0,         4'hF, 0, exp_be0, 1'b0);

        do_req("store word0",     1'b1, 32'h0,         32'h600D_F00D, 4'hF, 0, 32'h0, 1'b0);
        do_req("load misaligned", 1'b0, 32'h102,       32'h0,         4'hF, 0, 32'h0, 1'b1);
        do_req("store range",     1'b1, 32'h100,       32'hBAD0_BAD0, 4'hF, 0, 32'h0, 1'b1);
        do_req("store misalign",  1'b1, 32'h1,         32'h0000_0000, 4'hF, 0, 32'h0, 1'b1);
        do_req("load high addr",  1'b0, 32'h8000_0000, 32'h0,         4'hF, 0, 32'h0, 1'b1);
        do_req("load word0",      1'b0, 32'h0,         32'h0,         4'hF, 0, 32'h600D_F00D, 1'b0);

        do_req("backpressure", 1'b0, 32'h64, 32'h0, 4'hF, 5, 32'h0000_0019, 1'b0);

        do_req("store 0x20 old", 1'b1, 32'h20, 32'h0000_0005, 4'hF, 0, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("wait rsp_valid", rsp_valid, 0);
        check("wait req_ready", req_ready, 0);
        reset = 1'b1;
        #1;
        check("wait-reset req_ready", req_ready, 1);
        check("wait-reset rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_req("load 0x20 after reset", 1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h0000_0005, 1'b0);

        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h4;
        z_req_wdata = 32'h0C0F_FEE0; z_req_be = 4'hF;
        @(negedge clk);
        check("zero-wait req_ready", z_req_ready, 1);
        @(posedge clk);
        #1;
        z_req_we  = 1'b0;
        prev_acc  = 1'b1;
        acc_count = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("zero-wait rsp_valid", z_rsp_valid, prev_acc);
            if (prev_acc) begin
                check("zero-wait rdata", z_rsp_rdata, (i == 0) ? 32'h0 : 32'h0C0F_FEE0);
                check("zero-wait err", z_rsp_err, 0);
            end
            prev_acc  = z_req_valid && z_req_ready;
            acc_count = acc_count + (prev_acc ? 1 : 0);
        end
        check("zero-wait accepts", acc_count, 6);
        z_req_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
